// File: rtl/rx_ctrl_fsm.sv
// UART receive control: rx synchronizer, start-bit qualification, bit timing, frame length.
// Latency: rx_s lags rx by 2 clocks; START entered 1 clock after rx_s falls; btu is combinational.
// Backpressure: none; the datapath must consume every btu/done strobe as it occurs.
module rx_ctrl_fsm #(
    parameter int CNT_W      = 19,
    parameter int NUM_BITS_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [3:0] baud,
    input  logic       eight,
    input  logic       p_en,
    output logic       rx_s,
    output logic       start,
    output logic       btu,
    output logic       done,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

    state_t                state;
    logic                  rx_meta;
    logic [3:0]            baud_q;
    logic                  eight_q;
    logic                  p_en_q;
    logic [CNT_W-1:0]      bit_time;
    logic [CNT_W-1:0]      k_cnt;
    logic [CNT_W-1:0]      term;
    logic [NUM_BITS_W-1:0] bit_cnt;
    logic [NUM_BITS_W-1:0] last_bit;

    always_comb begin
        k_cnt = CNT_W'(109);
        case (baud_q)
            4'd0:    k_cnt = CNT_W'(333333);
            4'd1:    k_cnt = CNT_W'(83333);
            4'd2:    k_cnt = CNT_W'(41667);
            4'd3:    k_cnt = CNT_W'(20833);
            4'd4:    k_cnt = CNT_W'(10417);
            4'd5:    k_cnt = CNT_W'(5208);
            4'd6:    k_cnt = CNT_W'(2604);
            4'd7:    k_cnt = CNT_W'(1736);
            4'd8:    k_cnt = CNT_W'(868);
            4'd9:    k_cnt = CNT_W'(434);
            4'd10:   k_cnt = CNT_W'(217);
            default: k_cnt = CNT_W'(109);
        endcase
    end

    // START times only half a bit so every later sample lands mid-bit.
    assign term     = (state == START) ? ((k_cnt >> 1) - CNT_W'(1)) : (k_cnt - CNT_W'(1));
    assign btu      = ((state == START) || (state == DATA)) && (bit_time == term);
    assign last_bit = NUM_BITS_W'(7) + NUM_BITS_W'(eight_q) + NUM_BITS_W'(p_en_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            state    <= IDLE;
            start    <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            bit_time <= '0;
            bit_cnt  <= '0;
            baud_q   <= '0;
            eight_q  <= 1'b0;
            p_en_q   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    bit_time <= '0;
                    if (!rx_s) begin
                        state   <= START;
                        start   <= 1'b1;
                        busy    <= 1'b1;
                        baud_q  <= baud;
                        eight_q <= eight;
                        p_en_q  <= p_en;
                    end
                end
                START: begin
                    if (btu) begin
                        bit_time <= '0;
                        start    <= 1'b0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        bit_time <= bit_time + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (btu) begin
                        bit_time <= '0;
                        bit_cnt  <= bit_cnt + NUM_BITS_W'(1);
                        if (bit_cnt == last_bit) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        bit_time <= bit_time + CNT_W'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    bit_time <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_ctrl_fsm.sv
// Testbench for rx_ctrl_fsm: predicts strobe timing per frame from the baud table and frame rules.
module tb_rx_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [3:0] baud;
    logic       eight;
    logic       p_en;
    logic       rx_s, start, btu, done, busy;

    int n_chk  = 0;
    int n_fail = 0;
    int t      = 0;

    int btu_q[$], done_q[$], srise_q[$], sfall_q[$];
    int e_btu[$], e_done[$], e_srise[$], e_sfall[$];
    logic start_d = 1'b0;

    rx_ctrl_fsm #(.CNT_W(19), .NUM_BITS_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .baud (baud),
        .eight(eight),
        .p_en (p_en),
        .rx_s (rx_s),
        .start(start),
        .btu  (btu),
        .done (done),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Event log, stamped with the step number during which the strobe is visible.
    always @(negedge clk) begin
        if (btu === 1'b1) btu_q.push_back(t);
        if (done === 1'b1) done_q.push_back(t);
        if (start === 1'b1 && start_d !== 1'b1) srise_q.push_back(t);
        if (start !== 1'b1 && start_d === 1'b1) sfall_q.push_back(t);
        start_d <= start;
    end

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int kval(input logic [3:0] b);
        case (b)
            4'd0: return 333333;
            4'd1: return 83333;
            4'd2: return 41667;
            4'd3: return 20833;
            4'd4: return 10417;
            4'd5: return 5208;
            4'd6: return 2604;
            4'd7: return 1736;
            4'd8: return 868;
            4'd9: return 434;
            4'd10: return 217;
            default: return 109;
        endcase
    endfunction

    // Drives one full frame starting now; expectations use the config in force at the start bit.
    task automatic send_frame(input logic [7:0] data, input logic e8, input logic pe,
                              input logic [3:0] bd, input int chg_bit);
        int k, h, n, i0, nd;
        logic [10:0] bits;
        k  = kval(bd);
        h  = k / 2;
        nd = e8 ? 8 : 7;
        n  = nd + int'(pe) + 1;
        bits = '1;
        bits[0] = 1'b0;
        for (int b = 0; b < nd; b++) bits[1 + b] = data[b];
        if (pe) bits[1 + nd] = ^(data & (e8 ? 8'hFF : 8'h7F));
        eight = e8;
        p_en  = pe;
        baud  = bd;
        i0 = t;
        e_srise.push_back(i0 + 3);
        e_sfall.push_back(i0 + 3 + h);
        e_btu.push_back(i0 + 2 + h);
        for (int j = 1; j <= n; j++) e_btu.push_back(i0 + 2 + h + j * k);
        e_done.push_back(i0 + 3 + h + n * k);
        for (int b = 0; b <= n; b++) begin
            rx = bits[b];
            if (b == chg_bit) begin
                eight = 1'b0;
                baud  = 4'd7;
            end
            repeat (k) step();
        end
        rx = 1'b1;
    endtask

    task automatic compare_events(input string tag);
        chk({tag, ".n_btu"}, btu_q.size(), e_btu.size());
        for (int j = 0; j < e_btu.size() && j < btu_q.size(); j++)
            chk({tag, ".btu_t"}, btu_q[j], e_btu[j]);
        chk({tag, ".n_done"}, done_q.size(), e_done.size());
        for (int j = 0; j < e_done.size() && j < done_q.size(); j++)
            chk({tag, ".done_t"}, done_q[j], e_done[j]);
        chk({tag, ".n_srise"}, srise_q.size(), e_srise.size());
        for (int j = 0; j < e_srise.size() && j < srise_q.size(); j++)
            chk({tag, ".start_rise_t"}, srise_q[j], e_srise[j]);
        chk({tag, ".n_sfall"}, sfall_q.size(), e_sfall.size());
        for (int j = 0; j < e_sfall.size() && j < sfall_q.size(); j++)
            chk({tag, ".start_fall_t"}, sfall_q[j], e_sfall[j]);
        chk({tag, ".busy_idle"}, busy, 1'b0);
        btu_q.delete(); done_q.delete(); srise_q.delete(); sfall_q.delete();
        e_btu.delete(); e_done.delete(); e_srise.delete(); e_sfall.delete();
    endtask

    initial begin
        int i0;
        logic [7:0] d;
        logic [3:0] bd;
        logic e8, pe;

        rst = 1'b1; rx = 1'b1; baud = 4'd11; eight = 1'b1; p_en = 1'b0;
        repeat (3) step();
        chk("reset.start", start, 1'b0);
        chk("reset.btu", btu, 1'b0);
        chk("reset.done", done, 1'b0);
        chk("reset.busy", busy, 1'b0);
        chk("reset.rx_s", rx_s, 1'b1);
        rst = 1'b0;
        repeat (5) step();
        btu_q.delete(); done_q.delete(); srise_q.delete(); sfall_q.delete();

        // Synchronizer lag, then a 20-cycle low pulse that must be rejected at the half-bit point.
        i0 = t;
        rx = 1'b0;
        step();
        chk("sync.lag1", rx_s, 1'b1);
        step();
        chk("sync.lag2", rx_s, 1'b0);
        step();
        chk("false.start_hi", start, 1'b1);
        chk("false.busy_hi", busy, 1'b1);
        repeat (17) step();
        rx = 1'b1;
        e_srise.push_back(i0 + 3);
        e_sfall.push_back(i0 + 3 + 54);
        e_btu.push_back(i0 + 2 + 54);
        repeat (200) step();
        compare_events("false_start");

        send_frame(8'h55, 1'b1, 1'b0, 4'd11, -1);
        repeat (20) step();
        compare_events("8N1_b11");

        send_frame(8'hA3, 1'b1, 1'b1, 4'd8, -1);
        repeat (20) step();
        compare_events("8E1_b8");

        send_frame(8'h3C, 1'b0, 1'b0, 4'd8, -1);
        repeat (20) step();
        compare_events("7N1_b8");

        // Config flips to 7 bits / baud 7 during DATA; only the following frame may see it.
        send_frame(8'hC6, 1'b1, 1'b0, 4'd11, 3);
        repeat (20) step();
        send_frame(8'h19, 1'b0, 1'b0, 4'd7, -1);
        repeat (20) step();
        compare_events("cfg_change");

        send_frame(8'h81, 1'b1, 1'b0, 4'd11, -1);
        send_frame(8'h7E, 1'b1, 1'b0, 4'd11, -1);
        repeat (20) step();
        compare_events("back_to_back");

        for (int f = 0; f < 4; f++) begin
            d  = 8'($urandom);
            bd = 4'($urandom_range(15, 9));
            e8 = 1'($urandom_range(1, 0));
            pe = 1'($urandom_range(1, 0));
            send_frame(d, e8, pe, bd, -1);
            if ($urandom_range(1, 0) == 1) repeat (30) step();
        end
        repeat (20) step();
        compare_events("random");

        // Asynchronous reset in the middle of DATA: immediate IDLE, no done afterwards.
        baud = 4'd11; eight = 1'b1; p_en = 1'b0;
        rx = 1'b0;
        repeat (120) step();
        chk("midrst.pre_busy", busy, 1'b1);
        done_q.delete();
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.start", start, 1'b0);
        chk("midrst.rx_s", rx_s, 1'b1);
        repeat (2) step();
        rst = 1'b0;
        repeat (1200) step();
        chk("midrst.no_done", done_q.size(), 0);
        chk("midrst.idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
